// File: rtl/npu_mem_pkg.sv
// Shared memory-subsystem constants and helpers for the NPU RAM arbiters.
// Provides clog2, the RAM read-latency encodings and the default bus widths.
package npu_mem_pkg;

    localparam int RAM_LAT_COMB   = 0;
    localparam int RAM_LAT_REG    = 1;
    localparam int DEF_ADDR_WIDTH = 12;
    localparam int DEF_DATA_WIDTH = 8;

    // Ceiling log2; clog2(1) = 0.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/ram_rd_arbiter_rr_pick.sv
// rr_pick: combinational rotating-priority picker. Scans req_i starting at
// start_i (wrapping modulo N) and returns a one-hot grant of the first hit.
module rr_pick
    import npu_mem_pkg::*;
#(
    parameter int N  = 2,
    parameter int IW = (N > 1) ? clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] start_i,
    output logic [N-1:0]  gnt_o,
    output logic          found_o
);

    always_comb begin
        int idx;
        idx     = 0;
        gnt_o   = '0;
        found_o = 1'b0;
        for (int i = 0; i < N; i++) begin
            idx = (int'(start_i) + i) % N;
            if (!found_o && req_i[idx]) begin
                gnt_o[idx] = 1'b1;
                found_o    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ram_rd_arbiter.sv
// ram_rd_arbiter: round-robin read-port arbiter with bounded burst ownership.
// Optional per-requester grant / stall counters when RAM_ARB_STATS_EN is defined.
module ram_rd_arbiter
    import npu_mem_pkg::*;
#(
    parameter int NUM_REQ     = 2,
    parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int RAM_LATENCY = RAM_LAT_REG,
    parameter int MAX_BURST   = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0]         rsp_data,
    output logic                          ram_read_req,
    output logic [ADDR_WIDTH-1:0]         ram_read_addr,
    input  logic [DATA_WIDTH-1:0]         ram_read_data
`ifdef RAM_ARB_STATS_EN
    ,
    output logic [NUM_REQ*32-1:0]         stat_grants,
    output logic [31:0]                   stat_stall
`endif
);

    localparam int OW = (NUM_REQ > 1) ? clog2(NUM_REQ) : 1;
    localparam int BW = clog2(MAX_BURST + 1);

    logic [OW-1:0]      owner_q, owner_d;
    logic [BW-1:0]      burst_q, burst_d;
    logic [NUM_REQ-1:0] valid_g;
    logic [NUM_REQ-1:0] others;
    logic [NUM_REQ-1:0] grant;
    logic               owner_hit;
    logic               found;
    logic [OW-1:0]      start_idx;
    logic [OW-1:0]      grant_idx;

    // Requests are masked while reset is held so nothing is granted in reset.
    assign valid_g   = req_valid & {NUM_REQ{reset}};
    assign others    = valid_g & ~(NUM_REQ'(1) << owner_q);
    assign owner_hit = valid_g[owner_q] &&
                       ((burst_q < BW'(MAX_BURST)) || (others == '0));

    // Starting the scan at the owner keeps the burst; starting after it rotates.
    assign start_idx = owner_hit ? owner_q :
                       ((owner_q == OW'(NUM_REQ - 1)) ? '0 : owner_q + OW'(1));

    rr_pick #(
        .N  (NUM_REQ),
        .IW (OW)
    ) u_pick (
        .req_i   (valid_g),
        .start_i (start_idx),
        .gnt_o   (grant),
        .found_o (found)
    );

    always_comb begin
        grant_idx     = '0;
        ram_read_addr = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                grant_idx     = OW'(i);
                ram_read_addr = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
            end
        end
    end

    assign req_ready    = grant;
    assign ram_read_req = found;

    always_comb begin
        owner_d = owner_q;
        burst_d = burst_q;
        if (!found) begin
            burst_d = '0;
        end else if (grant_idx == owner_q) begin
            if (burst_q != BW'(MAX_BURST)) burst_d = burst_q + BW'(1);
        end else begin
            owner_d = grant_idx;
            burst_d = BW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            owner_q <= '0;
            burst_q <= '0;
        end else begin
            owner_q <= owner_d;
            burst_q <= burst_d;
        end
    end

    generate
        if (RAM_LATENCY == RAM_LAT_COMB) begin : g_rsp_comb
            assign rsp_valid = grant;
        end else begin : g_rsp_reg
            logic [NUM_REQ-1:0] rsp_tag_q;
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) rsp_tag_q <= '0;
                else        rsp_tag_q <= grant;
            end
            assign rsp_valid = rsp_tag_q;
        end
    endgenerate

    assign rsp_data = ram_read_data;

`ifdef RAM_ARB_STATS_EN
    logic [NUM_REQ*32-1:0] grants_q;
    logic [31:0]           stall_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            grants_q <= '0;
            stall_q  <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (grant[i]) grants_q[i*32 +: 32] <= grants_q[i*32 +: 32] + 32'd1;
            end
            if ((valid_g & ~grant) != '0) stall_q <= stall_q + 32'd1;
        end
    end

    assign stat_grants = grants_q;
    assign stat_stall  = stall_q;
`endif

endmodule

// File: doc/ram_rd_arbiter.md
Name: ram_rd_arbiter

Overview:
Shares the single read port of one on-chip `ram` instance between NUM_REQ requesters, such as the weight and activation loaders of the systolic system. It uses round-robin arbitration with bounded burst ownership. Each requester sees a valid/ready request channel and gets a tagged response one RAM_LATENCY after acceptance. Writes do not pass through this block.

Parameters:
NUM_REQ, 2, number of read requesters (2..8)
ADDR_WIDTH, 12, RAM address width
DATA_WIDTH, 8, RAM data width
RAM_LATENCY, 1, 0 = combinational RAM read (OUTPUT_REG=0), 1 = registered read (OUTPUT_REG=1)
MAX_BURST, 4, consecutive beats an owner may keep while others wait (>=1)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
req_valid  in  NUM_REQ  per-requester read request
req_addr  in  NUM_REQ*ADDR_WIDTH  flattened addresses; requester i occupies bits [i*ADDR_WIDTH +: ADDR_WIDTH]
req_ready  out  NUM_REQ  one-hot grant; transfer occurs when req_valid[i] && req_ready[i]
rsp_valid  out  NUM_REQ  one-hot; data on rsp_data belongs to requester i
rsp_data  out  DATA_WIDTH  shared response data
ram_read_req  out  1  to ram.read_req
ram_read_addr  out  ADDR_WIDTH  to ram.read_addr
ram_read_data  in  DATA_WIDTH  from ram.read_data

Behaviour:
- State:
  - owner (clog2(NUM_REQ) bits)
  - burst_cnt (0..MAX_BURST, saturating)
  - when RAM_LATENCY=1: tag register rsp_tag (NUM_REQ bits, one-hot or zero)
- Reset (reset low, async): owner=0, burst_cnt=0, rsp_tag=0. Hence rsp_valid=0, req_ready=0, ram_read_req=0. Any in-flight response is discarded.
- Grant (combinational, at most one bit set):
  - If req_valid[owner] && (burst_cnt < MAX_BURST, or no other req_valid set): grant = owner.
  - Else: grant = the first valid requester scanning owner+1, owner+2, ... modulo NUM_REQ.
  - No valid requester: grant = 0.
- req_ready = grant. A requester may assert valid without waiting for ready. It must hold req_valid and its address stable until accepted.
- ram_read_req = |grant. ram_read_addr = the granted requester's address; it is 0 when idle.
- Update on each clock:
  - If grant == owner bit: burst_cnt = sat(burst_cnt+1).
  - Else if grant != 0: owner = granted index, burst_cnt = 1.
  - If no grant: burst_cnt = 0, owner unchanged.
- Response path, RAM_LATENCY=0: rsp_valid = grant, rsp_data = ram_read_data, same cycle as acceptance.
- Response path, RAM_LATENCY=1: rsp_tag <= grant every cycle. rsp_valid = rsp_tag, rsp_data = ram_read_data, one cycle after acceptance. Back-to-back accepts give back-to-back responses; there is no bubble.
- No backpressure on responses: a requester must sink data in the cycle rsp_valid is set.
- Boundary cases:
  - MAX_BURST=1 gives pure round-robin.
  - A sole active requester is granted every cycle indefinitely; burst_cnt saturates.
  - An owner that drops valid mid-burst loses ownership immediately if another requester is valid.
  - Owner index wraps from NUM_REQ-1 to 0.

Optional Feature:
RAM_ARB_STATS_EN: when defined, adds these outputs:
- stat_grants: NUM_REQ*32-bit flattened, per-requester accepted-beat counters
- stat_stall: 32-bit, counts cycles in which any requester had valid && !ready

Counters wrap at 2^32 and are cleared by reset. When the macro is undefined, these ports and counters do not exist and behaviour is otherwise identical.

Decomposition:
- Shared package/header npu_mem_pkg: clog2 function, RAM_LAT_COMB=0 / RAM_LAT_REG=1 constants, default ADDR_WIDTH/DATA_WIDTH.
- One sub-module, rr_pick: combinational rotating-priority picker. Inputs: NUM_REQ request vector and a start index. Outputs: one-hot grant and found flag. Reused by later arbiters.

Test Plan:
- Reset: hold reset low 3 cycles with req_valid=2'b11 → req_ready, rsp_valid and ram_read_req all 0. After release, the first grant goes to requester 0.
- RAM_LATENCY=1, RAM preloaded mem[a]=a: requester 0 alone issues addresses 0,1,2,3 on consecutive cycles → ram_read_addr 0,1,2,3. rsp_valid[0] is set in cycles 2–5 with rsp_data 0,1,2,3.
- MAX_BURST=4, both requesters valid continuously → grant sequence 0,0,0,0,1,1,1,1,0,0,… Each response is tagged to the matching requester.
- MAX_BURST=1, NUM_REQ=3, all valid → grant rotation 0,1,2,0,1,2. RAM_LATENCY=0 returns each response in the same cycle as its grant.
- Requester 1 deasserts after 2 beats while requester 0 stays valid → requester 0 is granted for 6+ consecutive cycles beyond MAX_BURST.
- Reset pulse while a RAM_LATENCY=1 response is in flight → rsp_valid is 0 the following cycle and no stale data is tagged. With RAM_ARB_STATS_EN, counters read 0.
